// File: rtl/array_capture_buffer_if.sv
// Word stream between a producer and array_capture_buffer.
// The producer drives data/valid; the buffer answers with ready.
interface array_capture_buffer_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/array_capture_buffer.sv
// Collects a word stream into a DEPTH-entry array, freezes it once full,
// and holds the snapshot for a downstream monitor until released.
module array_capture_buffer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 64
) (
   input  logic                           CLK,
   input  logic                           ASYNCRESETN,
   input  logic                           start,
   input  logic                           hold_release,
   array_capture_buffer_if.slave          s,
   output logic [WIDTH-1:0]               arr [DEPTH],
   output logic                           arr_valid,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           dropped
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      HOLD
   } state_t;

   state_t state;
   logic   in_ready;

   assign s.in_ready = in_ready;

   // in_ready and arr_valid are registered alongside the state so no input
   // reaches an output combinationally.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state     <= IDLE;
         count     <= '0;
         dropped   <= '0;
         in_ready  <= 1'b0;
         arr_valid <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            arr[i] <= '0;
         end
      end else begin
         // start is honoured in every state, so its cycle never records a drop.
         if (start) begin
            dropped <= 1'b0;
         end else if (s.in_valid && !in_ready) begin
            dropped <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= FILL;
                  count     <= '0;
                  in_ready  <= 1'b1;
                  arr_valid <= 1'b0;
               end
            end

            FILL: begin
               if (start) begin
                  count <= '0;
               end else if (s.in_valid) begin
                  arr[count[AW-1:0]] <= s.in_data;
                  count              <= count + CW'(1);
                  if (count == CW'(DEPTH - 1)) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     arr_valid <= 1'b1;
                  end
               end
            end

            HOLD: begin
               if (start) begin
                  state     <= FILL;
                  count     <= '0;
                  in_ready  <= 1'b1;
                  arr_valid <= 1'b0;
               end else if (hold_release) begin
                  state     <= IDLE;
                  arr_valid <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               arr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_array_capture_buffer.sv
// Directed-vector bench for array_capture_buffer with hand-computed expectations.
module tb_array_capture_buffer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 64;

   logic             CLK;
   logic             ASYNCRESETN;
   logic             start;
   logic             hold_release;
   logic [WIDTH-1:0] arr [DEPTH];
   logic             arr_valid;
   logic [6:0]       count;
   logic             dropped;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   array_capture_buffer_if #(.WIDTH(WIDTH)) bus ();

   array_capture_buffer #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .start       (start),
      .hold_release(hold_release),
      .s           (bus.slave),
      .arr         (arr),
      .arr_valid   (arr_valid),
      .count       (count),
      .dropped     (dropped)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int unsigned cycles;
      int unsigned acc;

      ASYNCRESETN  = 1'b0;
      start        = 1'b0;
      hold_release = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_arr_valid", 32'(arr_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_dropped", 32'(dropped), 32'd0);
      check("rst_arr0", 32'(arr[0]), 32'd0);
      step();
      ASYNCRESETN = 1'b1;

      // Back-to-back fill 0x00..0x3F
      start = 1'b1;
      step();
      start = 1'b0;
      check("t1_ready_after_start", 32'(bus.in_ready), 32'd1);
      check("t1_count_after_start", 32'(count), 32'd0);
      cycles = 0;
      for (int i = 0; i < 64; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i);
         step();
         cycles++;
         if (i == 0)  check("t1_count_first", 32'(count), 32'd1);
         if (i == 62) check("t1_not_valid_early", 32'(arr_valid), 32'd0);
      end
      bus.in_valid = 1'b0;
      check("t1_cycles", cycles, 32'd64);
      check("t1_arr_valid", 32'(arr_valid), 32'd1);
      check("t1_in_ready", 32'(bus.in_ready), 32'd0);
      check("t1_count", 32'(count), 32'd64);
      check("t1_dropped", 32'(dropped), 32'd0);
      for (int i = 0; i < 64; i++) check($sformatf("t1_arr[%0d]", i), 32'(arr[i]), 32'(i));

      // Valid data in HOLD is rejected and flagged
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hFF;
         step();
         check("t2_in_ready_hold", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      check("t2_dropped", 32'(dropped), 32'd1);
      check("t2_count_hold", 32'(count), 32'd64);
      check("t2_arr0", 32'(arr[0]), 32'h00);
      check("t2_arr63", 32'(arr[63]), 32'h3F);
      hold_release = 1'b1;
      step();
      hold_release = 1'b0;
      check("t2_valid_after_rel", 32'(arr_valid), 32'd0);
      check("t2_in_ready_idle", 32'(bus.in_ready), 32'd0);
      check("t2_arr5_kept", 32'(arr[5]), 32'h05);
      check("t2_arr63_kept", 32'(arr[63]), 32'h3F);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t2_dropped_clr", 32'(dropped), 32'd0);
      check("t2_in_ready_fill", 32'(bus.in_ready), 32'd1);

      // Alternate-cycle fill 0xA0+i
      acc = 0;
      for (int k = 0; k < 127; k++) begin
         bus.in_valid = (k % 2 == 0);
         bus.in_data  = 8'(32'hA0 + acc);
         step();
         if (k % 2 == 0) acc++;
         if (k == 1)   check("t3_count_k1", 32'(count), 32'd1);
         if (k == 10)  check("t3_count_k10", 32'(count), 32'd6);
         if (k == 124) check("t3_not_valid_early", 32'(arr_valid), 32'd0);
      end
      bus.in_valid = 1'b0;
      check("t3_arr_valid", 32'(arr_valid), 32'd1);
      check("t3_count", 32'(count), 32'd64);
      check("t3_dropped", 32'(dropped), 32'd0);
      for (int i = 0; i < 64; i++) check($sformatf("t3_arr[%0d]", i), 32'(arr[i]), 32'hA0 + 32'(i));

      // start together with release in HOLD goes straight to FILL
      start        = 1'b1;
      hold_release = 1'b1;
      step();
      start        = 1'b0;
      hold_release = 1'b0;
      check("t4_arr_valid", 32'(arr_valid), 32'd0);
      check("t4_in_ready", 32'(bus.in_ready), 32'd1);
      check("t4_count", 32'(count), 32'd0);

      // Restart after 20 words; the handshake in the start cycle is discarded
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(32'h80 + 32'(i));
         step();
      end
      check("t5_count_20", 32'(count), 32'd20);
      start        = 1'b1;
      bus.in_data  = 8'h77;
      step();
      start = 1'b0;
      check("t5_count_restart", 32'(count), 32'd0);
      check("t5_in_ready", 32'(bus.in_ready), 32'd1);
      check("t5_arr20_stale", 32'(arr[20]), 32'hB4);
      check("t5_arr0_partial", 32'(arr[0]), 32'h80);
      for (int i = 0; i < 64; i++) begin
         bus.in_data = 8'(32'h40 + 32'(i));
         step();
         if (i == 62) check("t5_not_valid_early", 32'(arr_valid), 32'd0);
      end
      bus.in_valid = 1'b0;
      check("t5_arr_valid", 32'(arr_valid), 32'd1);
      check("t5_count", 32'(count), 32'd64);
      for (int i = 0; i < 64; i++) check($sformatf("t5_arr[%0d]", i), 32'(arr[i]), 32'h40 + 32'(i));

      // Asynchronous reset mid-fill, between edges
      hold_release = 1'b1;
      step();
      hold_release = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(32'hC0 + 32'(i));
         step();
      end
      bus.in_valid = 1'b0;
      check("t6_count_30", 32'(count), 32'd30);
      #2;
      ASYNCRESETN = 1'b0;
      #1;
      check("t6_in_ready", 32'(bus.in_ready), 32'd0);
      check("t6_count", 32'(count), 32'd0);
      check("t6_arr_valid", 32'(arr_valid), 32'd0);
      acc = 0;
      for (int i = 0; i < 64; i++) if (arr[i] != '0) acc++;
      check("t6_arr_nonzero", acc, 32'd0);
      step();
      ASYNCRESETN = 1'b1;

      // Drop in IDLE, then start together with valid does not flag a drop
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      step();
      check("t7_dropped_idle", 32'(dropped), 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      bus.in_valid = 1'b0;
      check("t7_dropped_start", 32'(dropped), 32'd0);
      check("t7_in_ready", 32'(bus.in_ready), 32'd1);
      check("t7_count", 32'(count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
